// File: rtl/uart_rx_reader.sv
// uart_rx_reader: AXI4-Lite read initiator that polls the uartlite status
// register, drains the RX FIFO one byte at a time into a single-entry
// valid/ready holding register, and keeps sticky line and bus error flags.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_WAIT   | idle gap between polls; also parks while a byte is held
//   ST_STAT_AR| status register read address phase (araddr 0x8)
//   ST_STAT_R | status register read data phase
//   ST_FIFO_AR| RX FIFO read address phase (araddr 0x0)
//   ST_FIFO_R | RX FIFO read data phase
module uart_rx_reader #(
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        overrun_err,
  output logic        frame_err,
  output logic        parity_err,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam int CW = (POLL_GAP == 0) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(POLL_GAP);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_STAT_AR = 3'd1,
    ST_STAT_R  = 3'd2,
    ST_FIFO_AR = 3'd3,
    ST_FIFO_R  = 3'd4
  } state_t;

  state_t        state, next;
  logic [CW-1:0] gap_cnt;
  logic          stat_ok;
  logic          fifo_load;
  logic          bus_set;
  logic          unused_rdata;

  assign unused_rdata = ^rdata[31:8];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= next;
  end

  // Next-state, response decode and AXI outputs decoded from state.
  always_comb begin
    next      = state;
    stat_ok   = 1'b0;
    fifo_load = 1'b0;
    bus_set   = 1'b0;
    arvalid   = (state == ST_STAT_AR) || (state == ST_FIFO_AR);
    rready    = (state == ST_STAT_R) || (state == ST_FIFO_R);
    araddr    = ((state == ST_FIFO_AR) || (state == ST_FIFO_R)) ? 4'h0 : 4'h8;
    unique case (state)
      ST_WAIT: begin
        if ((gap_cnt == '0) && !valid) next = ST_STAT_AR;
      end
      ST_STAT_AR: begin
        if (arready) next = ST_STAT_R;
      end
      ST_STAT_R: begin
        if (rvalid) begin
          if (rresp != RESP_OKAY) begin
            bus_set = 1'b1;
            next    = ST_WAIT;
          end else begin
            stat_ok = 1'b1;
            next    = rdata[0] ? ST_FIFO_AR : ST_WAIT;
          end
        end
      end
      ST_FIFO_AR: begin
        if (arready) next = ST_FIFO_R;
      end
      ST_FIFO_R: begin
        if (rvalid) begin
          if (rresp != RESP_OKAY) bus_set   = 1'b1;
          else                    fifo_load = 1'b1;
          next = ST_WAIT;
        end
      end
      default: next = ST_WAIT;
    endcase
  end

  // Poll gap timer: reload on every entry to WAIT, count down to zero and hold.
  // The count is frozen while a byte is held so the full gap always follows
  // the consumer taking the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state != ST_WAIT) && (next == ST_WAIT)) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == ST_WAIT) && (gap_cnt != '0) && !valid) begin
      gap_cnt <= gap_cnt - CW'(1);
    end
  end

  // Single-entry output holding register; data keeps its value after consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (fifo_load) begin
      data  <= rdata[7:0];
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_err <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      overrun_err <= (overrun_err & ~err_clr) | (stat_ok & rdata[5]);
      frame_err   <= (frame_err   & ~err_clr) | (stat_ok & rdata[6]);
      parity_err  <= (parity_err  & ~err_clr) | (stat_ok & rdata[7]);
      bus_err     <= (bus_err     & ~err_clr) | bus_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Directed testbench for uart_rx_reader with POLL_GAP = 4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_uart_rx_reader;

  localparam int unsigned GAP = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        overrun_err;
  logic        frame_err;
  logic        parity_err;
  logic        bus_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  uart_rx_reader #(.POLL_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .data(data), .valid(valid), .ready(ready),
    .overrun_err(overrun_err), .frame_err(frame_err), .parity_err(parity_err),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive helpers: each assumes it is called at a falling edge.
  task automatic ar_accept();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic r_respond(input logic [31:0] d, input logic [1:0] resp);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = 2'b00;
  endtask

  task automatic wait_arvalid(output int n);
    n = 0;
    while (!arvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 4'h8) begin
      errors++;
      $display("FAIL reset_axi: arvalid=%b rready=%b araddr=%h expected 0 0 8", arvalid, rready, araddr);
    end
    checks++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h expected 0 00", valid, data);
    end
    checks++;
    if ({overrun_err, frame_err, parity_err, bus_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_err: flags=%b expected 0000", {overrun_err, frame_err, parity_err, bus_err});
    end
    wait_arvalid(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL reset_first_ar: got cycle %0d expected 5", n);
    end
  endtask

  task automatic test_status_zero();
    int n;
    checks++;
    if (araddr !== 4'h8) begin
      errors++;
      $display("FAIL stat0_addr: araddr=%h expected 8", araddr);
    end
    ar_accept();
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL stat0_rphase: rready=%b arvalid=%b expected 1 0", rready, arvalid);
    end
    r_respond(32'h0, 2'b00);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL stat0_idle: arvalid=%b rready=%b valid=%b expected 0 0 0", arvalid, rready, valid);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 5 || araddr !== 4'h8) begin
      errors++;
      $display("FAIL stat0_gap1: gap=%0d araddr=%h expected 5 8", n, araddr);
    end
    ar_accept();
    r_respond(32'hFFFF_FF00, 2'b00);
    wait_arvalid(n);
    checks++;
    if (n !== 5 || araddr !== 4'h8 || valid !== 1'b0) begin
      errors++;
      $display("FAIL stat0_gap2: gap=%0d araddr=%h valid=%b expected 5 8 0", n, araddr, valid);
    end
  endtask

  task automatic test_byte_ready_low();
    int n;
    int extra_ar;
    ready = 1'b0;
    ar_accept();
    r_respond(32'h0000_0001, 2'b00);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 4'h0) begin
      errors++;
      $display("FAIL byte_fifo_ar: arvalid=%b araddr=%h expected 1 0", arvalid, araddr);
    end
    ar_accept();
    checks++;
    if (rready !== 1'b1 || araddr !== 4'h0) begin
      errors++;
      $display("FAIL byte_fifo_r: rready=%b araddr=%h expected 1 0", rready, araddr);
    end
    r_respond(32'h0000_00A5, 2'b00);
    checks++;
    if (valid !== 1'b1 || data !== 8'hA5) begin
      errors++;
      $display("FAIL byte_deliver: valid=%b data=%h expected 1 a5", valid, data);
    end
    extra_ar = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arvalid) extra_ar++;
    end
    checks++;
    if (extra_ar !== 0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL byte_hold: arvalid cycles=%0d valid=%b expected 0 1", extra_ar, valid);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || data !== 8'hA5) begin
      errors++;
      $display("FAIL byte_consume: valid=%b data=%h expected 0 a5", valid, data);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL byte_resume: gap=%0d expected 5", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    ready = 1'b1;
    ar_accept();
    r_respond(32'h0000_0001, 2'b00);
    ar_accept();
    r_respond(32'h1234_563C, 2'b00);
    checks++;
    if (valid !== 1'b1 || data !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h expected 1 3c", valid, data);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_period: got %0d expected 6 after valid (period 10)", n);
    end
    ar_accept();
    r_respond(32'h0000_0001, 2'b00);
    ar_accept();
    r_respond(32'h0000_005A, 2'b00);
    checks++;
    if (valid !== 1'b1 || data !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h expected 1 5a", valid, data);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_period2: got %0d expected 6", n);
    end
    ready = 1'b0;
  endtask

  task automatic test_ar_stall();
    int n;
    int bad;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (arvalid !== 1'b1 || araddr !== 4'h8) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0 || arvalid !== 1'b1) begin
      errors++;
      $display("FAIL stall_stable: unstable cycles=%0d arvalid=%b expected 0 1", bad, arvalid);
    end
    ar_accept();
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL stall_handshake: rready=%b arvalid=%b expected 1 0", rready, arvalid);
    end
    r_respond(32'h0, 2'b00);
    wait_arvalid(n);
  endtask

  task automatic test_status_errors();
    int n;
    ar_accept();
    r_respond(32'h0000_00E1, 2'b00);
    checks++;
    if ({overrun_err, frame_err, parity_err} !== 3'b111 || arvalid !== 1'b1 || araddr !== 4'h0) begin
      errors++;
      $display("FAIL err_set: flags=%b arvalid=%b araddr=%h expected 111 1 0",
               {overrun_err, frame_err, parity_err}, arvalid, araddr);
    end
    ar_accept();
    r_respond(32'h0000_0077, 2'b00);
    checks++;
    if (valid !== 1'b1 || data !== 8'h77) begin
      errors++;
      $display("FAIL err_byte: valid=%b data=%h expected 1 77", valid, data);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    wait_arvalid(n);
    ar_accept();
    err_clr = 1'b1;
    r_respond(32'h0000_0020, 2'b00);
    err_clr = 1'b0;
    checks++;
    if ({overrun_err, frame_err, parity_err} !== 3'b100) begin
      errors++;
      $display("FAIL err_set_wins: flags=%b expected 100", {overrun_err, frame_err, parity_err});
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if ({overrun_err, frame_err, parity_err, bus_err} !== 4'b0000) begin
      errors++;
      $display("FAIL err_clear: flags=%b expected 0000", {overrun_err, frame_err, parity_err, bus_err});
    end
    wait_arvalid(n);
  endtask

  task automatic test_bus_err();
    int n;
    ar_accept();
    r_respond(32'h0000_0001, 2'b00);
    ar_accept();
    r_respond(32'h0000_0099, 2'b10);
    checks++;
    if (bus_err !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL bus_fifo: bus_err=%b valid=%b expected 1 0", bus_err, valid);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 5 || araddr !== 4'h8) begin
      errors++;
      $display("FAIL bus_next_poll: gap=%0d araddr=%h expected 5 8", n, araddr);
    end
    ar_accept();
    r_respond(32'h0000_00E1, 2'b11);
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || overrun_err !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL bus_stat: arvalid=%b rready=%b ovr=%b par=%b expected 0 0 0 0",
               arvalid, rready, overrun_err, parity_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL bus_clear: bus_err=%b expected 0", bus_err);
    end
    wait_arvalid(n);
  endtask

  task automatic test_reset_mid();
    int n;
    ar_accept();
    r_respond(32'h0000_0001, 2'b00);
    ar_accept();
    checks++;
    if (rready !== 1'b1 || araddr !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_pre: rready=%b araddr=%h expected 1 0", rready, araddr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || valid !== 1'b0 || araddr !== 4'h8) begin
      errors++;
      $display("FAIL rstmid_drop: arvalid=%b rready=%b valid=%b araddr=%h expected 0 0 0 8",
               arvalid, rready, valid, araddr);
    end
    wait_arvalid(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL rstmid_first_ar: got cycle %0d expected 5", n);
    end
  endtask

  initial begin
    test_reset();
    test_status_zero();
    test_byte_ready_low();
    test_back_to_back();
    test_ar_stall();
    test_status_errors();
    test_bus_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
